// File: rtl/ultimate_if.sv
// ultimate_if: host-side bus of the ultimate matrix-multiply processor (load A/B, start, read C).
// cycle_count exists only when ULTIMATE_CYCLE_COUNT_EN is defined.
interface ultimate_if #(
  parameter int DIM    = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+$clog2(DIM)
);
  localparam int AW = $clog2(DIM*DIM);
  logic              start_process;
  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic              busy;
  logic              done;
`ifdef ULTIMATE_CYCLE_COUNT_EN
  logic [31:0]       cycle_count;
  modport master (output start_process, wr_en, wr_sel, wr_addr, wr_data, rd_addr,
                  input rd_data, busy, done, cycle_count);
  modport slave  (input start_process, wr_en, wr_sel, wr_addr, wr_data, rd_addr,
                  output rd_data, busy, done, cycle_count);
`else
  modport master (output start_process, wr_en, wr_sel, wr_addr, wr_data, rd_addr,
                  input rd_data, busy, done);
  modport slave  (input start_process, wr_en, wr_sel, wr_addr, wr_data, rd_addr,
                  output rd_data, busy, done);
`endif
endinterface

// File: rtl/ultimate.sv
// ultimate: N_CORES lockstep MAC cores computing C = A x B over register-file matrices.
// Optional ULTIMATE_CYCLE_COUNT_EN exposes the COMPUTE cycle counter on the bus.
module ultimate #(
  parameter int N_CORES = 2,
  parameter int DIM     = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 2*DATA_W+$clog2(DIM)
) (
  input logic      clock,
  input logic      reset,
  ultimate_if.slave bus
);
  localparam int AW = $clog2(DIM*DIM);
  localparam int KW = $clog2(DIM+1);
  localparam int CW = $clog2(DIM);
  localparam int RW = $clog2(DIM+N_CORES);
  localparam int L  = (DIM/N_CORES)*DIM*(DIM+1);
  localparam int NW = $clog2(L+1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [NW-1:0]     r_cnt;
  logic [RW-1:0]     r_row [N_CORES];
  logic [CW-1:0]     r_col [N_CORES];
  logic [KW-1:0]     r_k   [N_CORES];
  logic [ACC_W-1:0]  r_acc [N_CORES];
  logic [DATA_W-1:0] r_a   [DIM*DIM];
  logic [DATA_W-1:0] r_b   [DIM*DIM];
  logic [ACC_W-1:0]  r_c   [DIM*DIM];
  logic              w_run;

  assign w_run        = (r_state == COMPUTE) && (r_cnt != NW'(L));
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_data  = r_c[bus.rd_addr];
`ifdef ULTIMATE_CYCLE_COUNT_EN
  assign bus.cycle_count = 32'(r_cnt);
`endif

  // Cores run in lockstep, so one shared counter marks the end of the sweep.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      for (int c = 0; c < N_CORES; c++) begin
        r_row[c] <= '0;
        r_col[c] <= '0;
        r_k[c]   <= '0;
        r_acc[c] <= '0;
      end
    end else if (r_state == IDLE) begin
      for (int c = 0; c < N_CORES; c++) begin
        r_row[c] <= RW'(c);
        r_col[c] <= '0;
        r_k[c]   <= '0;
        r_acc[c] <= '0;
      end
      if (bus.start_process) begin
        r_state <= COMPUTE;
        r_busy  <= 1'b1;
        r_cnt   <= '0;
      end
    end else if (r_state == COMPUTE) begin
      if (w_run) begin
        r_cnt <= r_cnt + NW'(1);
        for (int c = 0; c < N_CORES; c++)
          if (r_k[c] != KW'(DIM)) begin
            r_acc[c] <= r_acc[c] + ACC_W'(r_a[AW'(r_row[c]*DIM + r_k[c])]) *
                                   ACC_W'(r_b[AW'(r_k[c]*DIM + r_col[c])]);
            r_k[c]   <= r_k[c] + KW'(1);
          end else begin
            r_acc[c] <= '0;
            r_k[c]   <= '0;
            r_col[c] <= (r_col[c] == CW'(DIM-1)) ? '0 : r_col[c] + CW'(1);
            r_row[c] <= (r_col[c] == CW'(DIM-1)) ? r_row[c] + RW'(N_CORES) : r_row[c];
          end
      end else begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end else if (!bus.start_process) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end

  // Row sets are disjoint per core, so C writes never collide.
  always_ff @(posedge clock) begin
    if (bus.wr_en && r_state != COMPUTE) begin
      if (bus.wr_sel) r_b[bus.wr_addr] <= bus.wr_data;
      else            r_a[bus.wr_addr] <= bus.wr_data;
    end
    for (int c = 0; c < N_CORES; c++)
      if (w_run && r_k[c] == KW'(DIM))
        r_c[AW'(r_row[c]*DIM + r_col[c])] <= r_acc[c];
  end
endmodule

// File: tb/tb_ultimate.sv
// tb_ultimate: directed scoreboard bench for ultimate (DIM=4, N_CORES=2, L=40).
module tb_ultimate;
  localparam int N  = 2;
  localparam int D  = 4;
  localparam int DW = 8;
  localparam int CWID = 18;
  localparam int AA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ultimate_if #(.DIM(D), .DATA_W(DW), .ACC_W(CWID)) u_if();
  ultimate #(.N_CORES(N), .DIM(D), .DATA_W(DW), .ACC_W(CWID)) dut (
    .clock(clk), .reset(rst), .bus(u_if.slave)
  );

  int     n_vec = 0;
  int     n_err = 0;
  int     ma [16];
  int     mb [16];
  longint exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < 16; i++) begin
      u_if.wr_en = 1'b1; u_if.wr_sel = 1'b0; u_if.wr_addr = AA'(i); u_if.wr_data = DW'(ma[i]);
      step();
      u_if.wr_sel = 1'b1; u_if.wr_data = DW'(mb[i]);
      step();
    end
    u_if.wr_en = 1'b0;
  endtask

  task automatic push_exp();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        longint s = 0;
        for (int k = 0; k < D; k++) s += longint'(ma[i*D+k]) * longint'(mb[k*D+j]);
        exp_q.push_back(s);
      end
  endtask

  task automatic check_c(input string tag);
    for (int a = 0; a < 16; a++) begin
      u_if.rd_addr = AA'(a);
      #1;
      chk($sformatf("%s_c%0d", tag, a), 64'(u_if.rd_data), exp_q.pop_front());
    end
  endtask

  // Raises start, optionally attempts an A[0]=7 write wr_at edges in, waits for done.
  task automatic run(input string tag, input int wr_at);
    int edges = 0;
    bit busy_ok = 1'b1;
    u_if.start_process = 1'b1;
    step();
    chk({tag, "_busy_rise"}, 64'(u_if.busy), 1);
    while (!u_if.done && edges < 200) begin
      if (!u_if.busy) busy_ok = 1'b0;
      u_if.wr_en = (edges == wr_at); u_if.wr_sel = 1'b0; u_if.wr_addr = '0; u_if.wr_data = 8'd7;
      step();
      edges++;
    end
    u_if.wr_en = 1'b0;
    chk({tag, "_latency"}, 64'(edges), 41);
    chk({tag, "_busy_held"}, 64'(busy_ok), 1);
    chk({tag, "_busy_fall"}, 64'(u_if.busy), 0);
`ifdef ULTIMATE_CYCLE_COUNT_EN
    chk({tag, "_cycle_count"}, 64'(u_if.cycle_count), 40);
`endif
  endtask

  initial begin
    bit busy_seen;
    bit done_low;
    u_if.start_process = 1'b0; u_if.wr_en = 1'b0; u_if.wr_sel = 1'b0;
    u_if.wr_addr = '0; u_if.wr_data = '0; u_if.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(u_if.busy), 0);
    chk("rst_done", 64'(u_if.done), 0);
`ifdef ULTIMATE_CYCLE_COUNT_EN
    chk("rst_cycle_count", 64'(u_if.cycle_count), 0);
`endif
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      ma[i] = (i / 4 == i % 4) ? 1 : 0;
      mb[i] = i;
    end
    load();
    push_exp();
    run("ident", -1);
    check_c("ident");

    push_exp();
    busy_seen = 1'b0;
    done_low = 1'b0;
    repeat (200) begin
      step();
      if (u_if.busy) busy_seen = 1'b1;
      if (!u_if.done) done_low = 1'b1;
    end
    chk("held_busy_seen", 64'(busy_seen), 0);
    chk("held_done_low", 64'(done_low), 0);
    check_c("held");
    u_if.start_process = 1'b0;
    step();
    chk("drop_done", 64'(u_if.done), 0);
    push_exp();
    run("rerun", -1);
    check_c("rerun");

    u_if.start_process = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      ma[i] = i + 1;
      mb[i] = (3 * i) % 17;
    end
    load();
    push_exp();
    run("busywr", 4);
    check_c("busywr");
    u_if.wr_en = 1'b1; u_if.wr_sel = 1'b0; u_if.wr_addr = '0; u_if.wr_data = 8'd7;
    step();
    u_if.wr_en = 1'b0;
    ma[0] = 7;
    u_if.start_process = 1'b0;
    step();
    push_exp();
    run("postwr", -1);
    check_c("postwr");

    u_if.start_process = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 255;
      mb[i] = 255;
    end
    load();
    push_exp();
    run("max", -1);
    u_if.rd_addr = AA'(15);
    #1;
    chk("max_c15_const", 64'(u_if.rd_data), 260100);
    check_c("max");

    u_if.start_process = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      ma[i] = int'($urandom_range(0, 255));
      mb[i] = int'($urandom_range(0, 255));
    end
    load();
    u_if.start_process = 1'b1;
    step();
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(u_if.busy), 0);
    chk("abort_done", 64'(u_if.done), 0);
    u_if.start_process = 1'b0;
    step();
    rst = 1'b0;
    step();
    push_exp();
    run("fresh", -1);
    check_c("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
